// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave with four 32-bit registers; B and R valid one cycle after the (later) handshake.
// AW/W are independently buffered one deep; READYs drop while a response is pending or a channel is held.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_OUT
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]                   regs [4];
  logic                          aw_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic                          w_full;
  logic [31:0]                   w_data_q;
  logic [3:0]                    w_strb_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          rvalid_q;
  logic [1:0]                    rresp_q;
  logic [31:0]                   rdata_q;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;
  logic                          wr_in_range;
  logic                          rd_in_range;
  logic                          unused;

  assign S_AXI_AWREADY = ARESETN && !aw_full && !bvalid_q;
  assign S_AXI_WREADY  = ARESETN && !w_full && !bvalid_q;
  assign S_AXI_ARREADY = ARESETN && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A write commits as soon as both halves are present, buffered or arriving this edge.
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr = aw_full ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;

  assign wr_in_range = (wr_addr >> 4) == '0;
  assign rd_in_range = (S_AXI_ARADDR >> 4) == '0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (commit) begin
        if (wr_in_range) begin
          for (int k = 0; k < 4; k++)
            if (wr_strb[k]) regs[wr_addr[3:2]][8*k +: 8] <= wr_data[8*k +: 8];
        end
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  // Reads sample regs before any same-edge write lands, so they see the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_in_range ? regs[S_AXI_ARADDR[3:2]] : '0;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  assign REG0_OUT = regs[0];
  assign REG1_OUT = regs[1];
  assign REG2_OUT = regs[2];
  assign REG3_OUT = regs[3];

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], aw_addr_q[1:0]};

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave built with a 6-bit address so 0x10+ is out of range.
module tb_axi4lite_reg_slave;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [3:0][31:0] reg_out;

  int vectors = 0;
  int miscompares = 0;

  axi4lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG0_OUT(reg_out[0]), .REG1_OUT(reg_out[1]), .REG2_OUT(reg_out[2]), .REG3_OUT(reg_out[3])
  );

  always #5 clk = ~clk;

  // Drivers: entered and left just after a rising edge; ok=0 means a handshake timed out.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done;
    int n;
    ok = 1; resp = 2'bxx; n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      aw_done = awvalid && awready;
      w_done  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) begin
      ok = 0; awvalid = 0; wvalid = 0; bready = 0;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid && n < 20);
    if (!bvalid) ok = 0;
    else resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit ok);
    bit done;
    int n;
    ok = 1; d = 'x; resp = 2'bxx; n = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (arvalid && n < 20) begin
      @(negedge clk);
      done = arready;
      @(posedge clk); #1;
      if (done) arvalid = 0;
      n++;
    end
    if (arvalid) begin
      ok = 0; arvalid = 0; rready = 0;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid && n < 20);
    if (!rvalid) ok = 0;
    else begin
      d = rdata; resp = rresp;
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_readys: got %b want 000", {awready, wready, arready});
    end
    vectors++;
    if ({bvalid, rvalid} !== 2'b00 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_resp: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h want all 0",
                              bvalid, rvalid, bresp, rresp, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (reg_out[i] !== 32'h0) begin
        miscompares++; $display("FAIL reset_reg%0d: got %h want 00000000", i, reg_out[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++; $display("FAIL post_reset_readys: got %b want 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_seq_write_read();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(4 * i), 32'(i + 1), 4'hF, resp, ok);
      vectors++;
      if (!ok || resp !== 2'b00) begin
        miscompares++; $display("FAIL seq_bresp[%0d]: ok=%0d got %b want 00", i, ok, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(4 * i), d, resp, ok);
      vectors++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
        miscompares++; $display("FAIL seq_read[%0d]: ok=%0d got %h/%b want %h/00", i, ok, d, resp, i + 1);
      end
    end
  endtask

  task automatic test_strobes();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    axi_write(6'h4, 32'hAABBCCDD, 4'hF, resp, ok);
    axi_write(6'h4, 32'h11223344, 4'h5, resp, ok);
    axi_read(6'h4, d, resp, ok);
    vectors++;
    if (!ok || d !== 32'hAA22CC44 || resp !== 2'b00) begin
      miscompares++; $display("FAIL strobe_read: ok=%0d got %h/%b want aa22cc44/00", ok, d, resp);
    end
  endtask

  task automatic test_channel_skew();
    awaddr = 6'h8; awvalid = 1;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1) begin
      miscompares++; $display("FAIL skew_awready_initial: got %b want 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (awready !== 1'b0 || bvalid !== 1'b0) begin
        miscompares++; $display("FAIL skew_hold[%0d]: awready=%b bvalid=%b want 0/0", c, awready, bvalid);
      end
      @(posedge clk); #1;
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    vectors++;
    if (wready !== 1'b1 || bvalid !== 1'b0) begin
      miscompares++; $display("FAIL skew_w_phase: wready=%b bvalid=%b want 1/0", wready, bvalid);
    end
    @(posedge clk); #1;
    wvalid = 0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_out[2] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL skew_commit: bvalid=%b bresp=%b reg2=%h want 1/00/deadbeef",
                              bvalid, bresp, reg_out[2]);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic test_backpressure();
    awaddr = 6'hC; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        miscompares++; $display("FAIL b_stall[%0d]: bvalid=%b bresp=%b awready=%b wready=%b want 1/00/0/0",
                                c, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || reg_out[3] !== 32'h12345678) begin
      miscompares++; $display("FAIL b_release: bvalid=%b awready=%b wready=%b reg3=%h want 0/1/1/12345678",
                              bvalid, awready, wready, reg_out[3]);
    end
    @(posedge clk); #1;
    araddr = 6'hC; arvalid = 1; rready = 0;
    @(posedge clk); #1;
    arvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rresp !== 2'b00 || arready !== 1'b0) begin
        miscompares++; $display("FAIL r_stall[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b want 1/12345678/00/0",
                                c, rvalid, rdata, rresp, arready);
      end
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++; $display("FAIL r_release: rvalid=%b arready=%b want 0/1", rvalid, arready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    awaddr = 6'h0; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h0;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++; $display("FAIL rw_same_readys: got %b want 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'h1 || bvalid !== 1'b1 || reg_out[0] !== 32'h55) begin
      miscompares++; $display("FAIL rw_same_edge: rvalid=%b rdata=%h bvalid=%b reg0=%h want 1/00000001/1/00000055",
                              rvalid, rdata, bvalid, reg_out[0]);
    end
    @(posedge clk); #1;
    bready = 0; rready = 0;
  endtask

  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    logic [3:0][31:0] expect_regs;
    expect_regs[0] = 32'h55;       expect_regs[1] = 32'hAA22CC44;
    expect_regs[2] = 32'hDEADBEEF; expect_regs[3] = 32'h12345678;
    axi_write(6'h10, 32'h5, 4'hF, resp, ok);
    vectors++;
    if (!ok || resp !== 2'b10) begin
      miscompares++; $display("FAIL oor_bresp: ok=%0d got %b want 10", ok, resp);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (reg_out[i] !== expect_regs[i]) begin
        miscompares++; $display("FAIL oor_reg%0d: got %h want %h", i, reg_out[i], expect_regs[i]);
      end
    end
    axi_read(6'h14, d, resp, ok);
    vectors++;
    if (!ok || d !== 32'h0 || resp !== 2'b10) begin
      miscompares++; $display("FAIL oor_read: ok=%0d got %h/%b want 00000000/10", ok, d, resp);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  resp;
    logic [31:0] d;
    bit ok;
    awaddr = 6'h4; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1 || reg_out[1] !== 32'h2) begin
      miscompares++; $display("FAIL mid_pre: bvalid=%b reg1=%h want 1/00000002", bvalid, reg_out[1]);
    end
    #1 rst_n = 0;
    #1;
    vectors++;
    if (bvalid !== 1'b0 || reg_out[1] !== 32'h0 || awready !== 1'b0) begin
      miscompares++; $display("FAIL mid_async: bvalid=%b reg1=%h awready=%b want 0/00000000/0",
                              bvalid, reg_out[1], awready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    axi_read(6'h4, d, resp, ok);
    vectors++;
    if (!ok || d !== 32'h0 || resp !== 2'b00) begin
      miscompares++; $display("FAIL mid_readback: ok=%0d got %h/%b want 00000000/00", ok, d, resp);
    end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_strobes();
    test_channel_skew();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
